// File: rtl/md_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit.
package md_pkg;

  localparam int unsigned DATA_W          = 32;
  localparam int unsigned CNT_W           = 8;
  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  typedef struct packed {
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
  } md_result_t;

  // Encodings 4-7 are reserved and behave as no-ops.
  function automatic logic md_op_legal(input logic [2:0] op);
    return (op[2] == 1'b0);
  endfunction

  function automatic logic md_op_is_div(input logic [2:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/md_busy_ctr.sv
// Loadable down-counter; done_c flags the final busy cycle (count == 1).
module md_busy_ctr
  import md_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done_c
);

  logic [CNT_W-1:0] count;

  // Load on operation accept, otherwise count down to zero and hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  assign done_c = (count == CNT_W'(1));

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit owning the HI and LO registers.
module md_unit
  import md_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        md_op,
  input  logic [DATA_W-1:0] rs_val,
  input  logic [DATA_W-1:0] rt_val,
  input  logic              hi_we,
  input  logic              lo_we,
  output logic              busy,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  md_state_e        state, state_nxt;
  logic             accept_c, commit_c, done_c, mt_ok_c;
  logic             res_we_c;
  md_result_t       res_c, pending;
  logic             pending_valid;
  logic [CNT_W-1:0] load_val_c;

  logic [2*DATA_W-1:0] prod_s, prod_u;
  logic [DATA_W-1:0]   a_mag, b_mag, b_safe, q_mag, r_mag, uq, ur;

  // Result datapath; divisor forced to 1 on divide-by-zero to keep the dividers defined.
  always_comb begin
    prod_s = {{DATA_W{rs_val[DATA_W-1]}}, rs_val} * {{DATA_W{rt_val[DATA_W-1]}}, rt_val};
    prod_u = {{DATA_W{1'b0}}, rs_val} * {{DATA_W{1'b0}}, rt_val};
    b_safe = (rt_val == '0) ? DATA_W'(1) : rt_val;
    a_mag  = rs_val[DATA_W-1] ? (~rs_val + DATA_W'(1)) : rs_val;
    b_mag  = rt_val[DATA_W-1] ? (~rt_val + DATA_W'(1)) : b_safe;
    q_mag  = a_mag / b_mag;
    r_mag  = a_mag % b_mag;
    uq     = rs_val / b_safe;
    ur     = rs_val % b_safe;
    res_c  = '0;
    case (md_op)
      MD_MULT:  res_c = prod_s;
      MD_MULTU: res_c = prod_u;
      MD_DIV: begin
        res_c.lo = (rs_val[DATA_W-1] ^ rt_val[DATA_W-1]) ? (~q_mag + DATA_W'(1)) : q_mag;
        res_c.hi = rs_val[DATA_W-1] ? (~r_mag + DATA_W'(1)) : r_mag;
      end
      MD_DIVU: begin
        res_c.lo = uq;
        res_c.hi = ur;
      end
      default: res_c = '0;
    endcase
    res_we_c = !(md_op_is_div(md_op) && (rt_val == '0));
  end

  // Next-state and strobes for IDLE/RUN sequencing.
  always_comb begin
    state_nxt = state;
    accept_c  = 1'b0;
    commit_c  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && md_op_legal(md_op)) begin
          accept_c  = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (done_c) begin
          commit_c  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign mt_ok_c    = (state == ST_IDLE) && !start;
  assign load_val_c = md_op_is_div(md_op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);

  md_busy_ctr u_busy_ctr (
    .clk      (clk),
    .reset    (reset),
    .load     (accept_c),
    .load_val (load_val_c),
    .done_c   (done_c)
  );

  // State register and registered busy flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == ST_RUN);
    end
  end

  // Capture the result at accept; divide-by-zero suppresses the later commit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending       <= '0;
      pending_valid <= 1'b0;
    end else if (accept_c) begin
      pending       <= res_c;
      pending_valid <= res_we_c;
    end
  end

  // HI/LO architectural registers: commit from pending, or mthi/mtlo when idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi <= '0;
      lo <= '0;
    end else if (commit_c) begin
      if (pending_valid) begin
        hi <= pending.hi;
        lo <= pending.lo;
      end
    end else if (mt_ok_c) begin
      if (hi_we) hi <= rs_val;
      if (lo_we) lo <= rs_val;
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: stimulus queues expectations, a monitor checks output events.
module tb_md_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start = 1'b0;
  logic [2:0]  md_op = 3'd0;
  logic [31:0] rs_val = 32'd0;
  logic [31:0] rt_val = 32'd0;
  logic        hi_we = 1'b0;
  logic        lo_we = 1'b0;
  logic        busy;
  logic [31:0] hi, lo;

  md_unit dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .md_op  (md_op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .hi_we  (hi_we),
    .lo_we  (lo_we),
    .busy   (busy),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  typedef enum int {K_OP, K_WR, K_RST} kind_e;
  typedef struct {
    kind_e       kind;
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    int          len;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  bit   done_req = 1'b0;

  task automatic push(input kind_e k, input string nm, input logic [31:0] eh, input logic [31:0] el,
                      input int len);
    exp_t e;
    e.kind = k; e.name = nm; e.hi = eh; e.lo = el; e.len = len;
    sb.push_back(e);
  endtask

  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eh, input logic [31:0] el, input int len, input string nm);
    push(K_OP, nm, eh, el, len);
    @(negedge clk);
    md_op = op; rs_val = a; rt_val = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (len + 2) @(negedge clk);
  endtask

  task automatic do_mt(input logic h, input logic l, input logic [31:0] v,
                       input logic [31:0] eh, input logic [31:0] el, input string nm);
    push(K_WR, nm, eh, el, 0);
    @(negedge clk);
    hi_we = h; lo_we = l; rs_val = v;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    @(negedge clk);
  endtask

  // Stimulus
  initial begin
    reset = 1'b1;
    push(K_RST, "reset", 32'h0, 32'h0, 0);
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    repeat (2) @(negedge clk);

    do_op(3'd0, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5, "mult_neg");
    do_op(3'd1, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, 5, "multu");
    do_op(3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10, "div_neg");
    do_op(3'd3, 32'd7, 32'd2, 32'd1, 32'd3, 10, "divu");
    do_mt(1'b1, 1'b0, 32'h1234_5678, 32'h1234_5678, 32'd3, "mthi");
    do_mt(1'b0, 1'b1, 32'h9ABC_DEF0, 32'h1234_5678, 32'h9ABC_DEF0, "mtlo");
    do_op(3'd3, 32'd7, 32'd0, 32'h1234_5678, 32'h9ABC_DEF0, 10, "divu_zero");
    do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 10, "div_ovf");

    // Reserved op: must not start anything (monitor flags any busy rise).
    @(negedge clk);
    md_op = 3'd5; rs_val = 32'd9; rt_val = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);

    do_mt(1'b1, 1'b1, 32'hCAFE_F00D, 32'hCAFE_F00D, 32'hCAFE_F00D, "mt_both");

    // mthi in the same cycle as start is ignored.
    push(K_OP, "mult_with_we", 32'h1, 32'h0, 5);
    @(negedge clk);
    md_op = 3'd0; rs_val = 32'h0001_0000; rt_val = 32'h0001_0000; start = 1'b1; hi_we = 1'b1;
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0;
    repeat (7) @(negedge clk);

    // start(div) and mthi during busy cycle 3 are ignored.
    push(K_OP, "mult_inject", 32'hFFFF_FFFF, 32'hFFFF_FFF1, 5);
    @(negedge clk);
    md_op = 3'd0; rs_val = 32'd3; rt_val = 32'hFFFF_FFFB; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    md_op = 3'd2; rs_val = 32'd100; rt_val = 32'd7; start = 1'b1; hi_we = 1'b1;
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0;
    repeat (6) @(negedge clk);

    // Async reset in busy cycle 4 of a div aborts it.
    push(K_OP, "div_aborted", 32'd2, 32'd14, 10);
    push(K_RST, "reset_mid", 32'h0, 32'h0, 0);
    @(negedge clk);
    md_op = 3'd2; rs_val = 32'd100; rt_val = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk);
    #2 reset = 1'b0;
    repeat (15) @(negedge clk);

    done_req = 1'b1;
  end

  // Monitor / checker
  int          cyc = 0;
  bit          in_run = 1'b0;
  int          run_len = 0;
  logic [31:0] prev_hi = 32'h0;
  logic [31:0] prev_lo = 32'h0;
  exp_t        cur;
  bit          ok;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", nm, act, expv);
    end
  endtask

  task automatic take(input kind_e k, output bit got, output exp_t e);
    got = 1'b0;
    e.kind = k; e.name = ""; e.hi = 32'h0; e.lo = 32'h0; e.len = 0;
    if (sb.size() == 0 || sb[0].kind != k) begin
      vectors++;
      miscompares++;
      $display("FAIL unexpected_event: kind %0d seen at cycle %0d with no matching expectation", k, cyc);
    end else begin
      e = sb.pop_front();
      got = 1'b1;
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      while (sb.size() > 0 && sb[0].kind != K_RST) void'(sb.pop_front());
      if (sb.size() > 0) begin
        cur = sb.pop_front();
        chk({cur.name, "_busy"}, 32'(busy), 32'h0);
        chk({cur.name, "_hi"}, hi, cur.hi);
        chk({cur.name, "_lo"}, lo, cur.lo);
      end
      in_run = 1'b0;
    end else if (busy) begin
      if (!in_run) begin
        in_run  = 1'b1;
        run_len = 0;
        if (sb.size() == 0 || sb[0].kind != K_OP) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_busy: busy rose at cycle %0d with no operation expected", cyc);
        end
      end
      run_len++;
      chk("hold_hi", hi, prev_hi);
      chk("hold_lo", lo, prev_lo);
    end else if (in_run) begin
      in_run = 1'b0;
      take(K_OP, ok, cur);
      if (ok) begin
        chk({cur.name, "_len"}, 32'(run_len), 32'(cur.len));
        chk({cur.name, "_hi"}, hi, cur.hi);
        chk({cur.name, "_lo"}, lo, cur.lo);
      end
    end else if (hi !== prev_hi || lo !== prev_lo) begin
      take(K_WR, ok, cur);
      if (ok) begin
        chk({cur.name, "_hi"}, hi, cur.hi);
        chk({cur.name, "_lo"}, lo, cur.lo);
      end
    end
    prev_hi = hi;
    prev_lo = lo;

    if (done_req) begin
      chk("sb_empty", 32'(sb.size()), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
    end else if (cyc > 20000) begin
      vectors++;
      miscompares++;
      $display("FAIL timeout: cycle %0d, expected completion before 20000", cyc);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
    end
  end

endmodule
